// File: rtl/rv32i_alu.sv
// RV32I integer ALU: add/sub, shifts and bitwise logic, one result register stage.
// One-cycle latency, one op per cycle; no backpressure, so each result is shown for exactly one cycle.
module rv32i_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_o,
    output logic [WIDTH-1:0] f,
    output logic             zero_o
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SLL = 3'b001,
        OP_SRA = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_SRL = 3'b101,
        OP_OR  = 3'b110,
        OP_AND = 3'b111
    } aluop_t;

    aluop_t           op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;

    assign op    = aluop_t'(aluop);
    // Only the low bits of b select the shift distance; upper bits are ignored.
    assign shamt = b[SHW-1:0];

    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_SLL: res = a << shamt;
            OP_SRL: res = a >> shamt;
            OP_SRA: res = WIDTH'($signed(a) >>> shamt);
            OP_XOR: res = a ^ b;
            OP_OR:  res = a | b;
            OP_AND: res = a & b;
            default: res = '0;
        endcase
    end

    // Flag is derived from the same combinational result that lands in f.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            f       <= '0;
            zero_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                f      <= res;
                zero_o <= (res == '0);
            end
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for rv32i_alu; expected results queued at issue, checked by a monitor.
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [2:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_o;
    logic [31:0] f;
    logic        zero_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] f;
        logic        z;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] ADD = 3'b000, SLL = 3'b001, SRA = 3'b010, SUB = 3'b011,
                           XOR = 3'b100, SRL = 3'b101, OR  = 3'b110, AND = 3'b111;

    rv32i_alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .aluop   (aluop),
        .a       (a),
        .b       (b),
        .valid_o (valid_o),
        .f       (f),
        .zero_o  (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Issue one op, queue its expected result, then scramble the inputs after the edge.
    task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ef);
        exp_t e;
        aluop   = op;
        a       = x;
        b       = y;
        valid_i = 1'b1;
        e.f = ef;
        e.z = (ef == 32'd0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        a     = $urandom;
        b     = $urandom;
        aluop = 3'($urandom_range(0, 7));
    endtask

    always @(negedge clk) begin
        if (valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got f=%h zero=%b with no pending result", f, zero_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (f !== e.f || zero_o !== e.z) begin
                    errors++;
                    $display("FAIL result: got f=%h zero=%b expected f=%h zero=%b", f, zero_o, e.f, e.z);
                end
            end
        end else if (sb.size() > 1) begin
            checks++;
            errors++;
            $display("FAIL bubble: got valid_o=0 expected 1 with %0d results pending", sb.size());
        end
    end

    initial begin
        rst     = 1'b0;
        valid_i = 1'b0;
        aluop   = 3'b000;
        a       = 32'd0;
        b       = 32'd0;
        #1;
        chk("reset_f", f, 32'd0);
        chk("reset_zero", {31'd0, zero_o}, 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);

        // Edges during reset must be ignored even with a valid request.
        valid_i = 1'b1;
        a       = 32'd5;
        b       = 32'd6;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ignore_f", f, 32'd0);
        chk("reset_ignore_valid", {31'd0, valid_o}, 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back directed vectors.
        send(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        send(SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        send(SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        send(SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
        send(SLL, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
        send(XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        send(OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        send(AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        send(ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
        send(SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000);
        send(SLL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000);
        send(SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
        send(SRA, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000);
        send(SRA, 32'h8000_0000, 32'hFFFF_FFE0, 32'h8000_0000);
        send(AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000);
        send(XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000);

        // Hold behaviour: idle cycles with changing operands keep the last result.
        send(ADD, 32'd3, 32'd4, 32'd7);
        valid_i = 1'b0;
        aluop   = SUB;
        a       = 32'd100;
        b       = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_f", f, 32'd7);
            chk("hold_valid", {31'd0, valid_o}, 32'd0);
            chk("hold_zero", {31'd0, zero_o}, 32'd0);
            a = $urandom;
        end

        // Async reset while a result is being presented drops it.
        aluop   = ADD;
        a       = 32'd10;
        b       = 32'd20;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_reset_valid", {31'd0, valid_o}, 32'd1);
        chk("pre_reset_f", f, 32'd30);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_f", f, 32'd0);
        chk("async_reset_zero", {31'd0, zero_o}, 32'd0);
        chk("async_reset_valid", {31'd0, valid_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_f", f, 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_release_valid", {31'd0, valid_o}, 32'd0);
        chk("post_release_f", f, 32'd0);

        send(SUB, 32'd100, 32'd1, 32'd99);
        send(OR,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
